// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read
// instruction RAM and presents PC+4 / instruction to IF/ID.
// Also keeps wrapping debug counters of delivered and stalled fetches.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 14,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               Pause,
   input  logic               Redirect,
   input  logic [31:0]        redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        IF_pc4_i,
   output logic [31:0]        IF_inst,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
);

   // Word-aligned reset PC; the low two bits of the parameter are ignored.
   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic [31:0] redirect_pc_w;
   logic        unused_bits;

   assign redirect_pc_w = {redirect_pc[31:2], 2'b00};

   // The RAM address comes straight from pc_next so the data lines up with
   // pc_q one clock later; upper address bits simply alias.
   assign imem_addr = pc_next[IMEM_AW+1:2];

   // Bits that are dropped on purpose (alignment and RAM aliasing).
   assign unused_bits = ^{redirect_pc[1:0], pc_next[1:0], pc_next[31:IMEM_AW+2]};

   // State register: BOOT after reset, RUN from the first edge after release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: BOOT lasts exactly one cycle, RUN holds until reset.
   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = BOOT;
      endcase
   end

   // Next fetch address: boot vector, then redirect, then pause, then +4.
   always_comb begin
      pc_next = pc_q + 32'd4;
      if (state == BOOT && !Redirect) begin
         pc_next = RESET_PC_W;
      end else if (Redirect) begin
         pc_next = redirect_pc_w;
      end else if (Pause) begin
         pc_next = pc_q;
      end
   end

   // PC register: tracks the address whose RAM data is visible this cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q <= RESET_PC_W;
      end else begin
         pc_q <= {pc_next[31:2], 2'b00};
      end
   end

   // Debug counters: only count in RUN; a redirect cycle counts as neither.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else if (state == RUN && !Redirect) begin
         if (Pause) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
      end
   end

   // Outputs: bubble during BOOT since the RAM has not yet been read.
   always_comb begin
      IF_pc4_i = pc_q + 32'd4;
      IF_inst  = (state == RUN) ? imem_rdata : NOP_INST;
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: boot sequence, pause, redirect,
// redirect-over-pause, PC wrap and asynchronous mid-run reset.
module tb_if_fetch;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          Pause = 1'b0;
   logic          Redirect = 1'b0;
   logic [31:0]   redirect_pc = 32'd0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic [31:0]   IF_pc4_i;
   logic [31:0]   IF_inst;
   logic [31:0]   fetch_cnt;
   logic [31:0]   stall_cnt;

   int checks = 0;
   int failures = 0;

   if_fetch #(
      .RESET_PC (32'h0000_0000),
      .IMEM_AW  (AW),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .Pause       (Pause),
      .Redirect    (Redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .IF_pc4_i    (IF_pc4_i),
      .IF_inst     (IF_inst),
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM model: word i holds 32'h1000_0000 + i.
   always @(posedge clk) begin
      imem_rdata <= 32'h1000_0000 + {18'd0, imem_addr};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] inst, input logic [31:0] pc4);
      check({tag, ".inst"}, IF_inst, inst);
      check({tag, ".pc4"}, IF_pc4_i, pc4);
   endtask

   task automatic check_reset_vals(input string tag);
      check_out(tag, 32'h13, 32'd4);
      check({tag, ".fcnt"}, fetch_cnt, 32'd0);
      check({tag, ".scnt"}, stall_cnt, 32'd0);
      check({tag, ".addr"}, {18'd0, imem_addr}, 32'd0);
   endtask

   // Hold reset for two edges, release, and walk through the boot cycles.
   task automatic do_boot(input string tag);
      rstn = 1'b0;
      Pause = 1'b0;
      Redirect = 1'b0;
      repeat (2) step();
      check_reset_vals({tag, ".rst"});
      rstn = 1'b1;
      #1;
      check_out({tag, ".c1"}, 32'h13, 32'd4);
      step();
      check_out({tag, ".c2"}, 32'h1000_0000, 32'd4);
      step();
      check_out({tag, ".c3"}, 32'h1000_0001, 32'd8);
      step();
      check_out({tag, ".c4"}, 32'h1000_0002, 32'd12);
      check({tag, ".fcnt"}, fetch_cnt, 32'd2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_boot("boot");

      // Pause three cycles while PC 8 is on the outputs.
      Pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("pause%0d", i), 32'h1000_0002, 32'd12);
      end
      Pause = 1'b0;
      check("pause.scnt", stall_cnt, 32'd3);
      check("pause.fcnt", fetch_cnt, 32'd2);
      step();
      check_out("pause.after", 32'h1000_0003, 32'd16);
      check("pause.fcnt2", fetch_cnt, 32'd3);

      // Redirect and Pause together at PC 12: redirect wins, no stall counted.
      Redirect = 1'b1;
      Pause = 1'b1;
      redirect_pc = 32'h20;
      step();
      check_out("rdp", 32'h1000_0008, 32'h24);
      check("rdp.scnt", stall_cnt, 32'd3);
      check("rdp.fcnt", fetch_cnt, 32'd3);
      Pause = 1'b0;

      // Redirect to 0x40 and to 0x43 from PC 4.
      redirect_pc = 32'h4;
      step();
      check_out("to4a", 32'h1000_0001, 32'd8);
      redirect_pc = 32'h40;
      step();
      check_out("rd40", 32'h1000_0010, 32'h44);
      redirect_pc = 32'h4;
      step();
      check_out("to4b", 32'h1000_0001, 32'd8);
      redirect_pc = 32'h43;
      step();
      check_out("rd43", 32'h1000_0010, 32'h44);
      check("rd.fcnt", fetch_cnt, 32'd3);
      Redirect = 1'b0;
      step();
      check_out("seq44", 32'h1000_0011, 32'h48);
      check("seq44.fcnt", fetch_cnt, 32'd4);

      // PC wrap at the top of the address space.
      Redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      check("wrap.addr0", {18'd0, imem_addr}, 32'h3FFF);
      step();
      Redirect = 1'b0;
      #1;
      check_out("wrap1", 32'h1000_3FFF, 32'd0);
      check("wrap.addr1", {18'd0, imem_addr}, 32'd0);
      step();
      check_out("wrap2", 32'h1000_0000, 32'd4);
      check("wrap.addr2", {18'd0, imem_addr}, 32'd1);
      check("wrap.fcnt", fetch_cnt, 32'd5);

      // Asynchronous reset in the middle of a cycle at PC 0x30.
      Redirect = 1'b1;
      redirect_pc = 32'h30;
      step();
      Redirect = 1'b0;
      check_out("pc30", 32'h1000_000C, 32'h34);
      check("pc30.scnt", stall_cnt, 32'd3);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_vals("midrst");
      do_boot("reboot");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined RISC-V core. It owns the program counter, drives a synchronous-read instruction memory, and presents `IF_pc4_i`/`IF_inst` to the IF/ID pipeline register. It obeys the same `Pause` and redirect controls that the hazard logic sends to IF/ID. Two wrapping counters of delivered and stalled fetches are kept for on-board debug display.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first instruction; bits [1:0] are ignored.
- `IMEM_AW`, default 14: instruction-memory word-address width.
- `NOP_INST`, default 32'h0000_0013: bubble instruction, `addi x0,x0,0`.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `rstn`  in  1: asynchronous, active-low reset.
- `Pause`  in  1: hold the current fetch. This is the same signal that stalls IF/ID.
- `Redirect`  in  1: taken branch or jump. It asserts together with IF/ID `Flush`.
- `redirect_pc`  in  32: target byte address; bits [1:0] are forced to 0.
- `imem_addr`  out  IMEM_AW: word address to the instruction RAM.
- `imem_rdata`  in  32: RAM data, valid one clock after `imem_addr` is sampled.
- `IF_pc4_i`  out  32: PC+4 of the instruction on `IF_inst`.
- `IF_inst`  out  32: fetched instruction, or `NOP_INST`.
- `fetch_cnt`  out  32: number of instructions delivered to IF/ID.
- `stall_cnt`  out  32: number of paused fetch cycles.

## Operation
- **Registers**
  - `pc_q`: PC of the instruction whose data is on `imem_rdata` in the current cycle.
  - `state`: BOOT or RUN.
  - The two counters.
- **Next fetch address**, `pc_next`, combinational. Priority:
  1. BOOT with no Redirect: `RESET_PC`.
  2. `Redirect`: `{redirect_pc[31:2],2'b00}`.
  3. `Pause`: `pc_q`.
  4. Otherwise: `pc_q+4`.
- `imem_addr` = `pc_next[IMEM_AW+1:2]` (combinational). Addresses above the RAM size alias.
- On posedge, `pc_q <= {pc_next[31:2],2'b00}`. PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- **Outputs**
  - `IF_pc4_i` = `pc_q+4` in every state.
  - `IF_inst` = `imem_rdata` in RUN and `NOP_INST` in BOOT.
- **State machine**
  - Reset: state = BOOT.
  - BOOT to RUN on the first posedge after `rstn` deasserts, regardless of Pause.
  - If Redirect is high in BOOT, the target is loaded instead of `RESET_PC`.
  - RUN stays in RUN until reset.
- **Pause**: the RAM is re-read at the same address, so `IF_inst` and `IF_pc4_i` stay stable for every paused cycle.
- **Redirect beats Pause.** Redirect needs no bubble: the target instruction is on `IF_inst` in the very next cycle. The wrong-path instruction present during the Redirect cycle is discarded by IF/ID `Flush`.
- **Counters**, updated on posedge in RUN only; both wrap at 2^32.
  - `fetch_cnt` +1 when `!Pause && !Redirect`.
  - `stall_cnt` +1 when `Pause && !Redirect`.

## Timing
- **Reset values** (asynchronous, immediate when `rstn`=0):
  - `pc_q`=`RESET_PC`, state=BOOT.
  - `IF_pc4_i`=`RESET_PC+4`, `IF_inst`=`NOP_INST`.
  - `fetch_cnt`=`stall_cnt`=0.
  - `imem_addr`=`RESET_PC[IMEM_AW+1:2]`.
- **First instruction**: cycle 1 after reset release is BOOT and shows a NOP. From cycle 2, `IF_inst`=`mem[RESET_PC]`.
- **Throughput**: one instruction per cycle with no stall.
- **Redirect latency**: a redirect sampled at edge N puts `mem[target]` on `IF_inst` after edge N, with `IF_pc4_i`=target+4.
- **Pause**: zero-cycle response. The outputs at edge N+1 equal those before edge N while `Pause`=1.
- **Reset mid-run**: outputs revert asynchronously to the reset values, and the next release repeats the BOOT cycle.
- `Pause`/`Redirect` are assumed to be driven from the same clock domain. No handshake beyond these levels.

## Test plan
- **Reset/boot**, `RESET_PC`=0, RAM word i = 32'h1000_0000+i:
  - Hold rstn=0, then release.
  - Cycle 1: `IF_inst`=0x13, `IF_pc4_i`=4.
  - Cycle 2: 0x1000_0000/4.
  - Cycle 3: 0x1000_0001/8.
  - `fetch_cnt`=2 after cycle 3's edge.
- **Pause for 3 cycles** while showing PC 8: `IF_inst`=0x1000_0002 and `IF_pc4_i`=12 are held for all 3 cycles; next comes 0x1000_0003. `stall_cnt`=3 and `fetch_cnt` is unchanged.
- **Redirect** to 0x40 (and to 0x43) at PC 4: the next cycle gives `IF_inst`=0x1000_0010 and `IF_pc4_i`=0x44 for both targets. `fetch_cnt` is not incremented in the redirect cycle.
- **Redirect and Pause** both high at PC 12 with target 0x20: the next cycle shows 0x1000_0008/0x24, and `stall_cnt` is unchanged.
- **Wrap**: redirect to 0xFFFF_FFFC, then run 2 cycles. `IF_pc4_i` goes 0 then 4, and `imem_addr` goes all-ones then 0.
- **Reset mid-run** at PC 0x30 with counters nonzero: all outputs return to the reset values within the same cycle, and the boot sequence repeats as in the first scenario.
